// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin snooping bus arbiter (cache req/grant -> snoop broadcast -> optional memory rd/wr -> per-cache response)
module snoop_bus_arbiter #(
  parameter int NUM_CACHES = 4,
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CACHES-1:0]    req_valid,
  input  logic [NUM_CACHES*2-1:0]  req_type,
  input  logic [NUM_CACHES*AW-1:0] req_addr,
  input  logic [NUM_CACHES*DW-1:0] req_data,
  output logic [NUM_CACHES-1:0]    grant,
  input  logic [NUM_CACHES-1:0]    shared_in,
  output logic                     snoop_valid,
  output logic [1:0]               snoop_type,
  output logic [AW-1:0]            snoop_addr,
  output logic [DW-1:0]            snoop_data,
  output logic [NUM_CACHES-1:0]    snoop_src,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_ack,
  output logic [NUM_CACHES-1:0]    resp_valid,
  output logic [DW-1:0]            resp_data,
  output logic                     resp_shared,
  output logic                     resp_err
);
  localparam int LW = NUM_CACHES > 1 ? $clog2(NUM_CACHES) : 1;
  typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_t;
  state_t state, nstate;
  logic [LW-1:0] last_grant, src_idx, off, win;
  logic [NUM_CACHES-1:0] rot, src_r;
  logic found, shared_r;
  logic [1:0] typ_r, sel_type;
  logic [AW-1:0] addr_r, sel_addr;
  logic [DW-1:0] data_r, line_r, sel_data;
  int sum;
  always_comb begin
    rot = NUM_CACHES'({req_valid, req_valid} >> (int'(last_grant) + 1));
    off = '0;
    found = 1'b0;
    for (int k = NUM_CACHES - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = LW'(k);
      end
    sum = int'(last_grant) + 1 + int'(off);
    win = LW'(sum >= NUM_CACHES ? sum - NUM_CACHES : sum);
  end
  always_comb begin
    grant = (state == IDLE && found && !reset) ? NUM_CACHES'(1) << win : '0;
    nstate = state == IDLE  ? (found ? SNOOP : IDLE)
           : state == SNOOP ? ((typ_r == 2'b00 || typ_r == 2'b10) ? MEM : RESP)
           : state == MEM   ? (mem_ack ? RESP : MEM)
           : IDLE;
    snoop_valid = state == SNOOP;
    snoop_type = typ_r;
    snoop_addr = addr_r;
    snoop_data = data_r;
    snoop_src = src_r;
    mem_rd = state == MEM && typ_r == 2'b00;
    mem_wr = state == MEM && typ_r == 2'b10;
    mem_addr = addr_r;
    mem_wdata = data_r;
    resp_valid = state == RESP ? src_r : '0;
    resp_data = (state == RESP && typ_r == 2'b00) ? line_r : '0;
    resp_shared = state == RESP && shared_r;
    resp_err = state == RESP && typ_r == 2'b11;
  end
  always_comb begin
    sel_type = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CACHES; i++)
      if (grant[i]) begin
        sel_type = req_type[i*2 +: 2];
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= LW'(NUM_CACHES - 1);
      src_idx <= '0;
      src_r <= '0;
      typ_r <= '0;
      addr_r <= '0;
      data_r <= '0;
      line_r <= '0;
      shared_r <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IDLE && found) begin
        typ_r <= sel_type;
        addr_r <= sel_addr;
        data_r <= sel_data;
        src_r <= grant;
        src_idx <= win;
      end
      if (state == SNOOP) shared_r <= |(shared_in & ~src_r);
      if (state == MEM && mem_ack) line_r <= mem_rdata;
      if (state == RESP) last_grant <= src_idx;
    end
  end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed and randomized checks of snoop_bus_arbiter against a transaction-level model
module tb_snoop_bus_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, grant, shared_in, snoop_src, resp_valid;
  logic [N*2-1:0] req_type;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic snoop_valid, mem_rd, mem_wr, mem_ack, resp_shared, resp_err;
  logic [1:0] snoop_type;
  logic [AW-1:0] snoop_addr, mem_addr;
  logic [DW-1:0] snoop_data, mem_wdata, mem_rdata, resp_data;
  logic [1:0] ptype [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pdata [N];
  logic [319:0] allout;
  logic [N-1:0] pend;
  int last;
  int compared = 0;
  int mismatched = 0;
  snoop_bus_arbiter #(.NUM_CACHES(N), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data), .grant(grant), .shared_in(shared_in),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
    .snoop_data(snoop_data), .snoop_src(snoop_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared), .resp_err(resp_err)
  );
  always #5 clock = ~clock;
  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_type[g*2 +: 2] = ptype[g];
    assign req_addr[g*AW +: AW] = paddr[g];
    assign req_data[g*DW +: DW] = pdata[g];
  end
  assign allout = 320'({grant, snoop_valid, snoop_type, snoop_addr, snoop_data, snoop_src, mem_rd, mem_wr,
                        mem_addr, mem_wdata, resp_valid, resp_data, resp_shared, resp_err});
  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic new_req(input int p);
    ptype[p] = 2'($urandom);
    paddr[p] = $urandom;
    pdata[p] = {$urandom, $urandom};
  endtask
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid = '0;
    mem_ack = 1'b0;
    pend = '0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("reset_outputs", allout, 320'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    last = N - 1;
  endtask
  // One whole transaction: the model picks the round-robin winner from pend and
  // derives every expected output cycle by cycle (grant, snoop, mem phase, resp).
  task automatic txn(input logic [N-1:0] sh, input int lat, input logic [DW-1:0] rd);
    int w;
    logic [N-1:0] oh;
    logic [1:0] t;
    logic hit;
    w = 0;
    hit = 1'b0;
    for (int i = 1; i <= N; i++)
      if (!hit && pend[(last + i) % N]) begin
        hit = 1'b1;
        w = (last + i) % N;
      end
    oh = N'(1) << w;
    t = ptype[w];
    @(posedge clock); #1;
    req_valid = pend;
    mem_ack = 1'($urandom);
    shared_in = N'($urandom);
    @(negedge clock);
    chk("grant", 320'(grant), 320'(oh));
    chk("idle_quiet", 320'({snoop_valid, mem_rd, mem_wr, resp_valid}), 320'(0));
    pend[w] = 1'b0;
    @(posedge clock); #1;
    req_valid = pend;
    shared_in = sh;
    mem_ack = 1'($urandom);
    @(negedge clock);
    chk("snoop", 320'({snoop_valid, snoop_src, snoop_type, snoop_addr, snoop_data}),
        320'({1'b1, oh, t, paddr[w], pdata[w]}));
    chk("snoop_quiet", 320'({grant, mem_rd, mem_wr, resp_valid}), 320'(0));
    if (t == 2'd0 || t == 2'd2)
      for (int k = 1; k <= lat; k++) begin
        @(posedge clock); #1;
        mem_ack = k == lat;
        mem_rdata = k == lat ? rd : {$urandom, $urandom};
        shared_in = N'($urandom);
        @(negedge clock);
        chk("mem", 320'({mem_rd, mem_wr, mem_addr, grant, snoop_valid, resp_valid}),
            320'({t == 2'd0, t == 2'd2, paddr[w], {N{1'b0}}, 1'b0, {N{1'b0}}}));
        if (t == 2'd2) chk("mem_wdata", 320'(mem_wdata), 320'(pdata[w]));
      end
    @(posedge clock); #1;
    mem_ack = 1'($urandom);
    mem_rdata = {$urandom, $urandom};
    shared_in = N'($urandom);
    @(negedge clock);
    chk("resp", 320'({resp_valid, resp_data, resp_shared, resp_err, mem_rd, mem_wr, grant, snoop_valid}),
        320'({oh, (t == 2'd0) ? rd : {DW{1'b0}}, |(sh & ~oh), t == 2'd3, 2'b00, {N{1'b0}}, 1'b0}));
    last = w;
  endtask
  initial begin
    reset = 1'b1;
    req_valid = '0;
    shared_in = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int p = 0; p < N; p++) new_req(p);
    do_reset();
    ptype[2] = 2'd0;
    paddr[2] = 32'h40;
    pend = 4'b0100;
    txn(4'b0100, 2, {8{8'hA5}});
    do_reset();
    for (int p = 0; p < N; p++) new_req(p);
    pend = 4'b1011;
    for (int n = 0; n < 3; n++) txn(N'($urandom), $urandom_range(1, 3), {$urandom, $urandom});
    ptype[1] = 2'd1;
    pend = 4'b0010;
    txn(4'b0110, 2, {$urandom, $urandom});
    ptype[3] = 2'd2;
    pdata[3] = 64'h1234_5678_9abc_def0;
    pend = 4'b1000;
    txn(N'($urandom), 3, {$urandom, $urandom});
    ptype[0] = 2'd3;
    pend = 4'b0001;
    txn(4'b1111, 2, {$urandom, $urandom});
    ptype[2] = 2'd0;
    paddr[2] = $urandom;
    pend = 4'b0100;
    @(posedge clock); #1;
    req_valid = pend;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("rst_mid_grant", 320'(grant), 320'(4'b0100));
    @(posedge clock); #1;
    req_valid = '0;
    pend = '0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_mid_mem_rd", 320'(mem_rd), 320'(1'b1));
    @(posedge clock); #1;
    reset = 1'b1;
    mem_ack = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clock);
    chk("rst_mid_outputs", allout, 320'(0));
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("rst_mid_no_resp", allout, 320'(0));
    last = N - 1;
    for (int p = 0; p < N; p++) new_req(p);
    pend = '1;
    txn(N'($urandom), 1, {$urandom, $urandom});
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] add, drop;
      add = N'($urandom);
      drop = ($urandom_range(0, 3) == 0) ? (N'($urandom) & pend) : '0;
      for (int p = 0; p < N; p++) if (add[p] && !pend[p]) new_req(p);
      pend = (pend | add) & ~drop;
      if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
      txn(N'($urandom), $urandom_range(1, 4), {$urandom, $urandom});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
